// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver with 16x-style oversampling, mid-bit sampling, start-glitch rejection,
// framing-error detection and a single-entry valid/ready holding register.
module uart_rx_oversample #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  FULL_LAST = OS_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StRecover
    } state_e;

    state_e             state_q, state_d;
    logic               sync1_q, sync2_q;
    logic               rx_s;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [OS_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;
    logic               tick;
    logic               deliver;

    assign rx_s = sync2_q;
    assign tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;

        // Tick timebase runs only while a frame is in progress.
        if (state_q != StIdle) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
            if (tick) begin
                tick_cnt_d = tick_cnt_q + OS_W'(1);
            end
        end

        case (state_q)
            StIdle: begin
                div_cnt_d  = '0;
                tick_cnt_d = '0;
                if (!rx_s) begin
                    shift_d = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick && tick_cnt_q == HALF_LAST) begin
                    tick_cnt_d = '0;
                    if (rx_s) begin
                        state_d = StIdle;
                    end else begin
                        bit_idx_d = 3'd0;
                        state_d   = StData;
                    end
                end
            end
            StData: begin
                if (tick && tick_cnt_q == FULL_LAST) begin
                    tick_cnt_d         = '0;
                    shift_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (tick && tick_cnt_q == FULL_LAST) begin
                    tick_cnt_d = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StRecover;
                    end
                end
            end
            StRecover: begin
                // A held-low break stays here so it reports only one framing error.
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
        if (deliver) begin
            if (!valid_q || data_ready) begin
                data_d  = shift_d;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            div_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            div_cnt_q   <= div_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: table of single frames plus hand-written sequences
// for timing, glitch, break, overrun, same-cycle accept and mid-frame reset.
module tb_uart_rx_oversample;

    localparam int unsigned CLK_FREQ = 1600;
    localparam int unsigned BAUD     = 10;
    localparam int unsigned OS       = 16;
    localparam int          BIT_CYC  = 160;
    // Start drive -> first cycle data_valid is visible: 2 sync + 1520 to stop sample + 1 load.
    localparam int          DV_LAT   = 1523;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    int         acc_cnt = 0;
    int         fe_cnt  = 0;
    int         ov_cnt  = 0;
    logic [7:0] last_byte = 8'h00;

    uart_rx_oversample #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard: counts accepted bytes and pulse cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_cnt = fe_cnt + 1;
            if (overrun) ov_cnt = ov_cnt + 1;
            if (data_valid && data_ready) begin
                acc_cnt   = acc_cnt + 1;
                last_byte = data_out;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx = bits[k];
            wait_cycles(BIT_CYC);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_acc;
        logic [7:0] exp_data;
        int         exp_fe;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    int a0, f0, o0, cnt;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[3] = '{8'h01, 1'b1, 1, 8'h01, 0};
        vecs[4] = '{8'h80, 1'b1, 1, 8'h80, 0};
        vecs[5] = '{8'h6E, 1'b1, 1, 8'h6E, 0};
        vecs[6] = '{8'h55, 1'b0, 0, 8'h00, 1};
        vecs[7] = '{8'hFF, 1'b0, 0, 8'h00, 1};

        rst        = 1'b1;
        rx         = 1'b1;
        data_ready = 1'b1;
        wait_cycles(3);
        check("reset_data_out", 32'(data_out), 32'h00);
        check("reset_data_valid", 32'(data_valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        wait_cycles(5);

        // Exact latency from start-bit drive to data_valid.
        cnt = 0;
        fork
            send_frame(8'h96, 1'b1);
            begin
                while (!data_valid && cnt < 2000) begin
                    wait_cycles(1);
                    cnt++;
                    if (cnt == 800) check("busy_mid_frame", 32'(busy), 32'h1);
                end
                check("dv_latency", 32'(cnt), 32'(DV_LAT));
                check("dv_latency_byte", 32'(data_out), 32'h96);
            end
        join
        rx = 1'b1;
        wait_cycles(200);

        for (int i = 0; i < NV; i++) begin
            a0 = acc_cnt; f0 = fe_cnt; o0 = ov_cnt;
            send_frame(vecs[i].data, vecs[i].stop);
            rx = 1'b1;
            wait_cycles(200);
            check($sformatf("vec%0d_accepts", i), 32'(acc_cnt - a0), 32'(vecs[i].exp_acc));
            if (vecs[i].exp_acc != 0)
                check($sformatf("vec%0d_byte", i), 32'(last_byte), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_frame_err", i), 32'(fe_cnt - f0), 32'(vecs[i].exp_fe));
            check($sformatf("vec%0d_overrun", i), 32'(ov_cnt - o0), 32'h0);
            check($sformatf("vec%0d_busy_idle", i), 32'(busy), 32'h0);
        end

        // Start-bit glitch, then a good frame.
        a0 = acc_cnt; f0 = fe_cnt;
        rx = 1'b0;
        wait_cycles(40);
        rx = 1'b1;
        wait_cycles(200);
        check("glitch_no_accept", 32'(acc_cnt - a0), 32'h0);
        check("glitch_busy", 32'(busy), 32'h0);
        send_frame(8'h3C, 1'b1);
        rx = 1'b1;
        wait_cycles(200);
        check("glitch_next_accepts", 32'(acc_cnt - a0), 32'h1);
        check("glitch_next_byte", 32'(last_byte), 32'h3C);
        check("glitch_frame_err", 32'(fe_cnt - f0), 32'h0);

        // Bad stop bit followed by a long break: one frame_err only.
        a0 = acc_cnt; f0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        wait_cycles(1000);
        check("break_busy", 32'(busy), 32'h1);
        rx = 1'b1;
        wait_cycles(200);
        send_frame(8'h0F, 1'b1);
        rx = 1'b1;
        wait_cycles(200);
        check("break_frame_err", 32'(fe_cnt - f0), 32'h1);
        check("break_accepts", 32'(acc_cnt - a0), 32'h1);
        check("break_byte", 32'(last_byte), 32'h0F);

        // Overrun: consumer stalled across two frames.
        data_ready = 1'b0;
        a0 = acc_cnt; o0 = ov_cnt;
        send_frame(8'h11, 1'b1);
        rx = 1'b1;
        wait_cycles(50);
        send_frame(8'h22, 1'b1);
        rx = 1'b1;
        wait_cycles(200);
        check("ovr_valid", 32'(data_valid), 32'h1);
        check("ovr_data_kept", 32'(data_out), 32'h11);
        check("ovr_pulse", 32'(ov_cnt - o0), 32'h1);
        check("ovr_no_accept", 32'(acc_cnt - a0), 32'h0);
        data_ready = 1'b1;
        wait_cycles(1);
        check("ovr_drain_valid", 32'(data_valid), 32'h0);
        check("ovr_drain_byte", 32'(last_byte), 32'h11);
        check("ovr_drain_accepts", 32'(acc_cnt - a0), 32'h1);

        // Accept in the exact stop-sample cycle of the next frame: reload, no overrun.
        data_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        rx = 1'b1;
        wait_cycles(200);
        a0 = acc_cnt; o0 = ov_cnt;
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (DV_LAT - 1) @(posedge clk);
                #1;
                data_ready = 1'b1;
                wait_cycles(1);
                data_ready = 1'b0;
                check("same_cycle_valid", 32'(data_valid), 32'h1);
                check("same_cycle_data", 32'(data_out), 32'h77);
            end
        join
        rx = 1'b1;
        wait_cycles(200);
        check("same_cycle_overrun", 32'(ov_cnt - o0), 32'h0);
        check("same_cycle_accepts", 32'(acc_cnt - a0), 32'h1);
        check("same_cycle_old_byte", 32'(last_byte), 32'h11);

        // Reset during data bit 3 while 0x77 is still held.
        fork
            send_frame(8'hC3, 1'b1);
            begin
                wait_cycles(700);
                rst = 1'b1;
                wait_cycles(1);
                rst = 1'b0;
                check("midrst_data_out", 32'(data_out), 32'h00);
                check("midrst_valid", 32'(data_valid), 32'h0);
                check("midrst_frame_err", 32'(frame_err), 32'h0);
                check("midrst_overrun", 32'(overrun), 32'h0);
                check("midrst_busy", 32'(busy), 32'h0);
            end
        join
        rx = 1'b1;
        data_ready = 1'b1;
        wait_cycles(1500);
        a0 = acc_cnt; f0 = fe_cnt;
        send_frame(8'hC3, 1'b1);
        rx = 1'b1;
        wait_cycles(200);
        check("post_rst_accepts", 32'(acc_cnt - a0), 32'h1);
        check("post_rst_byte", 32'(last_byte), 32'hC3);
        check("post_rst_frame_err", 32'(fe_cnt - f0), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
